// File: rtl/cache_fill_fsm.sv
// Cache miss fill requester: fetches one aligned block back-to-back, installs each returned word, then tags it.
// Define FILL_MISS_COUNT_EN to add the miss_count output (count of fills started, wraps at 16 bits).
module cache_fill_fsm #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_detected,
   input  logic [ADDR_WIDTH-1:0] miss_address,
   input  logic                  memory_data_valid,
   input  logic [15:0]           memory_data,
   output logic                  memory_enable,
   output logic [ADDR_WIDTH-1:0] memory_address,
   output logic                  fsm_busy,
   output logic                  write_data_array,
   output logic                  write_tag_array,
   output logic [ADDR_WIDTH-1:0] cache_word_addr,
`ifdef FILL_MISS_COUNT_EN
   output logic [15:0]           miss_count,
`endif
   output logic [15:0]           cache_word_data
);
   localparam int CW = $clog2(BLOCK_WORDS) + 1;
   localparam logic [CW-1:0]         CNT_END  = CW'(BLOCK_WORDS);
   localparam logic [CW-1:0]         CNT_LAST = CW'(BLOCK_WORDS - 1);
   localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
   localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CW-1:0]         req_cnt_q, req_cnt_d;
   logic [CW-1:0]         rcv_cnt_q, rcv_cnt_d;
   logic                  req_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         base_q    <= '0;
         req_cnt_q <= '0;
         rcv_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         req_cnt_q <= req_cnt_d;
         rcv_cnt_q <= rcv_cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      req_cnt_d        = req_cnt_q;
      rcv_cnt_d        = rcv_cnt_q;
      req_vld          = 1'b0;
      memory_enable    = 1'b0;
      memory_address   = '0;
      fsm_busy         = 1'b0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      cache_word_addr  = '0;
      case (state_q)
         IDLE: begin
            if (miss_detected) begin
               base_d    = miss_address & ~OFS_MASK;
               req_cnt_d = '0;
               rcv_cnt_d = '0;
               state_d   = FILL;
            end
         end
         FILL: begin
            fsm_busy         = 1'b1;
            req_vld          = (req_cnt_q < CNT_END);
            memory_enable    = req_vld;
            // base is block-aligned, so the word offset never carries out of the block
            memory_address   = base_q + (ADDR_WIDTH'(req_cnt_q) << 1);
            cache_word_addr  = base_q + (ADDR_WIDTH'(rcv_cnt_q) << 1);
            write_data_array = memory_data_valid;
            if (req_vld) begin
               req_cnt_d = req_cnt_q + CNT_ONE;
            end
            if (memory_data_valid) begin
               rcv_cnt_d = rcv_cnt_q + CNT_ONE;
               if (rcv_cnt_q == CNT_LAST) begin
                  write_tag_array = 1'b1;
                  state_d         = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cache_word_data = memory_data;

`ifdef FILL_MISS_COUNT_EN
   logic [15:0] miss_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         miss_count_q <= '0;
      end else if (state_q == IDLE && state_d == FILL) begin
         miss_count_q <= miss_count_q + 16'd1;
      end
   end

   assign miss_count = miss_count_q;
`endif

endmodule
